// File: rtl/icache_assoc_pkg.sv
// Shared constants, state encoding and address-field width helpers for icache_assoc.
package icache_assoc_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOOKUP = 2'b00,
    WAIT   = 2'b01,
    RESP   = 2'b10
  } state_t;

  // Byte offset width covering one line (word select plus the ignored byte bits).
  function automatic int unsigned calc_off(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned word_size,
                                             input int unsigned line_words,
                                             input int unsigned num_sets);
    return word_size - calc_off(line_words) - calc_idx_w(num_sets);
  endfunction

  // A single-way cache still carries a 1-bit way index.
  function automatic int unsigned calc_way_w(input int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way_select.sv
// Combinational per-set way logic: tag compare, hit way and replacement victim.
module icache_way_select
  import icache_assoc_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned TAG_W    = 26,
  parameter int unsigned WAY_W    = calc_way_w(NUM_WAYS)
) (
  input  logic [TAG_W-1:0]          i_tag,
  input  logic [NUM_WAYS*TAG_W-1:0] i_way_tags,
  input  logic [NUM_WAYS-1:0]       i_way_valid,
  input  logic [WAY_W-1:0]          i_rr_ptr,
  output logic [NUM_WAYS-1:0]       o_hit_onehot,
  output logic                      o_hit,
  output logic [WAY_W-1:0]          o_hit_way,
  output logic [WAY_W-1:0]          o_victim,
  output logic                      o_set_full
);

  logic w_found_free;

  // Parallel compare; victim is the lowest invalid way, else the round-robin pointer.
  always_comb begin
    o_hit_onehot = '0;
    o_hit_way    = '0;
    o_victim     = i_rr_ptr;
    w_found_free = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      o_hit_onehot[w] = i_way_valid[w] && (i_way_tags[w*TAG_W +: TAG_W] == i_tag);
      if (o_hit_onehot[w]) begin
        o_hit_way = WAY_W'(w);
      end
      if (!i_way_valid[w] && !w_found_free) begin
        o_victim     = WAY_W'(w);
        w_found_free = 1'b1;
      end
    end
    o_hit      = |o_hit_onehot;
    o_set_full = &i_way_valid;
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement,
// whole-cache flush and hit/miss counters.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_SIZE-1:0]            pc,
  input  logic                            flush,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_line,
  input  logic                            mem_ready,
  output logic                            mem_req,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            instr,
  output logic                            stall,
  output logic [CNT_W-1:0]                hit_count,
  output logic [CNT_W-1:0]                miss_count
);

  localparam int unsigned OFF    = calc_off(LINE_WORDS);
  localparam int unsigned WSEL_W = OFF - 2;
  localparam int unsigned IDX_W  = calc_idx_w(NUM_SETS);
  localparam int unsigned TAG_W  = calc_tag_w(WORD_SIZE, LINE_WORDS, NUM_SETS);
  localparam int unsigned WAY_W  = calc_way_w(NUM_WAYS);

  logic [WORD_SIZE-1:0] r_data  [NUM_SETS][NUM_WAYS][LINE_WORDS];
  logic [TAG_W-1:0]     r_tag   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
  logic [WAY_W-1:0]     r_rr    [NUM_SETS];

  state_t               r_state, w_next_state;
  logic [WORD_SIZE-1:0] r_miss_pc, r_mem_addr, r_instr;
  logic [WAY_W-1:0]     r_fill_way;
  logic                 r_stall, r_mem_req, r_flush_pending;
  logic [CNT_W-1:0]     r_hit_cnt, r_miss_cnt;

  logic [WSEL_W-1:0]         w_pc_word, w_miss_word;
  logic [IDX_W-1:0]          w_pc_idx, w_miss_idx, w_sel_idx;
  logic [TAG_W-1:0]          w_pc_tag, w_miss_tag;
  logic [NUM_WAYS*TAG_W-1:0] w_set_tags;
  logic [NUM_WAYS-1:0]       w_set_valid, w_hit_onehot;
  logic                      w_hit, w_set_full, w_fill;
  logic [WAY_W-1:0]          w_hit_way, w_victim;
  logic                      w_unused_bits;

  assign w_pc_word   = pc[OFF-1:2];
  assign w_pc_idx    = pc[OFF+IDX_W-1:OFF];
  assign w_pc_tag    = pc[WORD_SIZE-1:OFF+IDX_W];
  assign w_miss_word = r_miss_pc[OFF-1:2];
  assign w_miss_idx  = r_miss_pc[OFF+IDX_W-1:OFF];
  assign w_miss_tag  = r_miss_pc[WORD_SIZE-1:OFF+IDX_W];
  // Outside LOOKUP the set under consideration is the one being filled.
  assign w_sel_idx   = (r_state == LOOKUP) ? w_pc_idx : w_miss_idx;
  assign w_fill      = rst && (r_state == WAIT) && mem_ready;
  assign w_unused_bits = &{pc[1:0], r_miss_pc[1:0], w_hit_onehot};

  // Gather the selected set's tags and valid bits for the way selector.
  always_comb begin
    w_set_tags  = '0;
    w_set_valid = r_valid[w_sel_idx];
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      w_set_tags[w*TAG_W +: TAG_W] = r_tag[w_sel_idx][w];
    end
  end

  icache_way_select #(
    .NUM_WAYS (NUM_WAYS),
    .TAG_W    (TAG_W),
    .WAY_W    (WAY_W)
  ) u_way_select (
    .i_tag        (w_pc_tag),
    .i_way_tags   (w_set_tags),
    .i_way_valid  (w_set_valid),
    .i_rr_ptr     (r_rr[w_sel_idx]),
    .o_hit_onehot (w_hit_onehot),
    .o_hit        (w_hit),
    .o_hit_way    (w_hit_way),
    .o_victim     (w_victim),
    .o_set_full   (w_set_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= LOOKUP;
    else      r_state <= w_next_state;
  end

  // Next-state logic: LOOKUP -> WAIT on a miss, WAIT -> RESP on mem_ready, RESP -> LOOKUP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOOKUP:  if (!flush && !w_hit) w_next_state = WAIT;
      WAIT:    if (mem_ready)        w_next_state = RESP;
      RESP:                          w_next_state = LOOKUP;
      default:                       w_next_state = LOOKUP;
    endcase
  end

  // Line data and tag storage, written by a completing fill.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        r_data[w_miss_idx][w_victim][k] <= mem_line[k*WORD_SIZE +: WORD_SIZE];
      end
      r_tag[w_miss_idx][w_victim] <= w_miss_tag;
    end
  end

  // Control registers: valid bits, replacement pointers, outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
      r_stall         <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_miss_pc       <= '0;
      r_fill_way      <= '0;
      r_instr         <= WORD_SIZE'(NOP);
      r_flush_pending <= 1'b0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      case (r_state)
        LOOKUP: begin
          if (flush) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
            r_instr         <= WORD_SIZE'(NOP);
            r_flush_pending <= 1'b0;
          end else if (w_hit) begin
            r_instr   <= r_data[w_pc_idx][w_hit_way][w_pc_word];
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else begin
            r_stall    <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {pc[WORD_SIZE-1:OFF], {OFF{1'b0}}};
            r_miss_pc  <= pc;
            r_instr    <= WORD_SIZE'(NOP);
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (flush) r_flush_pending <= 1'b1;
          if (mem_ready) begin
            r_valid[w_miss_idx][w_victim] <= 1'b1;
            r_fill_way <= w_victim;
            if (w_set_full) begin
              r_rr[w_miss_idx] <= (r_rr[w_miss_idx] == WAY_W'(NUM_WAYS - 1))
                                  ? '0 : r_rr[w_miss_idx] + WAY_W'(1);
            end
            r_mem_req <= 1'b0;
          end
        end
        RESP: begin
          // The pending flush is applied only after the filled word has been read out.
          r_instr <= r_data[w_miss_idx][r_fill_way][w_miss_word];
          r_stall <= 1'b0;
          if (r_flush_pending || flush) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
          end
          r_flush_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign instr      = r_instr;
  assign stall      = r_stall;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed self-checking bench for icache_assoc (4 sets, 4-word lines, 2 ways).
module tb_icache_assoc;

  localparam int unsigned WS = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned CW = 32;
  localparam logic [31:0] NOPV = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WS-1:0]     pc = '0;
  logic              flush = 1'b0;
  logic [LW*WS-1:0]  mem_line = '0;
  logic              mem_ready = 1'b0;
  logic              mem_req;
  logic [WS-1:0]     mem_addr;
  logic [WS-1:0]     instr;
  logic              stall;
  logic [CW-1:0]     hit_count;
  logic [CW-1:0]     miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_assoc #(
    .WORD_SIZE  (WS),
    .LINE_WORDS (LW),
    .NUM_SETS   (NS),
    .NUM_WAYS   (NW),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .mem_line   (mem_line),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .instr      (instr),
    .stall      (stall),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  function automatic logic [LW*WS-1:0] mk_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; mem_ready = 1'b0; pc = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // Completes an outstanding fill: delay idle cycles, a mem_ready pulse, then the RESP cycle.
  task automatic serve_fill(input logic [LW*WS-1:0] line, input int unsigned delay);
    mem_line = line;
    repeat (delay) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (stall !== 1'b0)        begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    total++; if (mem_req !== 1'b0)      begin bad++; $display("FAIL reset_req got=%0h exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0)    begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (instr !== NOPV)        begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOPV); end
    total++; if (hit_count !== 32'd0)   begin bad++; $display("FAIL reset_hits got=%0d exp=0", hit_count); end
    total++; if (miss_count !== 32'd0)  begin bad++; $display("FAIL reset_misses got=%0d exp=0", miss_count); end
  endtask

  task automatic test_cold_miss();
    do_reset();
    pc = 32'h100;
    tick();
    total++; if (mem_req !== 1'b1)       begin bad++; $display("FAIL cold_req got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h100)   begin bad++; $display("FAIL cold_addr got=%h exp=100", mem_addr); end
    total++; if (stall !== 1'b1)         begin bad++; $display("FAIL cold_stall got=%0h exp=1", stall); end
    total++; if (instr !== NOPV)         begin bad++; $display("FAIL cold_instr got=%h exp=%h", instr, NOPV); end
    total++; if (miss_count !== 32'd1)   begin bad++; $display("FAIL cold_misses got=%0d exp=1", miss_count); end
    mem_line = {32'hD, 32'hC, 32'hB, 32'hA};
    tick(); tick(); tick();
    total++; if (mem_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL cold_hold got=%0h/%0h exp=1/1", mem_req, stall); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (mem_req !== 1'b0)       begin bad++; $display("FAIL cold_req_drop got=%0h exp=0", mem_req); end
    total++; if (stall !== 1'b1)         begin bad++; $display("FAIL cold_stall_wait got=%0h exp=1", stall); end
    tick();
    total++; if (instr !== 32'hA)        begin bad++; $display("FAIL cold_fill_instr got=%h exp=a", instr); end
    total++; if (stall !== 1'b0)         begin bad++; $display("FAIL cold_unstall got=%0h exp=0", stall); end
  endtask

  // Continues directly from the cold-miss state: line 0x100 is resident.
  task automatic test_same_line_hits();
    pc = 32'h104; tick();
    total++; if (instr !== 32'hB || stall !== 1'b0) begin bad++; $display("FAIL hit_104 got=%h/%0h exp=b/0", instr, stall); end
    pc = 32'h108; tick();
    total++; if (instr !== 32'hC || stall !== 1'b0) begin bad++; $display("FAIL hit_108 got=%h/%0h exp=c/0", instr, stall); end
    pc = 32'h10C; tick();
    total++; if (instr !== 32'hD || stall !== 1'b0) begin bad++; $display("FAIL hit_10c got=%h/%0h exp=d/0", instr, stall); end
    total++; if (hit_count !== 32'd3)   begin bad++; $display("FAIL hit_count got=%0d exp=3", hit_count); end
    total++; if (miss_count !== 32'd1)  begin bad++; $display("FAIL hit_misses got=%0d exp=1", miss_count); end
  endtask

  task automatic test_assoc();
    do_reset();
    pc = 32'h100; tick();
    serve_fill(mk_line(32'h1000), 1);
    total++; if (instr !== 32'h1000)    begin bad++; $display("FAIL assoc_fill0 got=%h exp=1000", instr); end
    pc = 32'h140; tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h140) begin bad++; $display("FAIL assoc_miss1 got=%0h/%h exp=1/140", mem_req, mem_addr); end
    serve_fill(mk_line(32'h2000), 2);
    total++; if (instr !== 32'h2000)    begin bad++; $display("FAIL assoc_fill1 got=%h exp=2000", instr); end
    pc = 32'h100; tick();
    total++; if (instr !== 32'h1000 || stall !== 1'b0) begin bad++; $display("FAIL assoc_hit100 got=%h/%0h exp=1000/0", instr, stall); end
    pc = 32'h144; tick();
    total++; if (instr !== 32'h2001 || stall !== 1'b0) begin bad++; $display("FAIL assoc_hit144 got=%h/%0h exp=2001/0", instr, stall); end
    pc = 32'h108; tick();
    total++; if (instr !== 32'h1002 || stall !== 1'b0) begin bad++; $display("FAIL assoc_hit108 got=%h/%0h exp=1002/0", instr, stall); end
    pc = 32'h14C; tick();
    total++; if (instr !== 32'h2003 || stall !== 1'b0) begin bad++; $display("FAIL assoc_hit14c got=%h/%0h exp=2003/0", instr, stall); end
    total++; if (miss_count !== 32'd2)  begin bad++; $display("FAIL assoc_misses got=%0d exp=2", miss_count); end
    total++; if (hit_count !== 32'd4)   begin bad++; $display("FAIL assoc_hits got=%0d exp=4", hit_count); end
  endtask

  task automatic test_round_robin();
    do_reset();
    pc = 32'h100; tick(); serve_fill(mk_line(32'h1000), 0);
    pc = 32'h140; tick(); serve_fill(mk_line(32'h2000), 0);
    pc = 32'h180; tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin bad++; $display("FAIL rr_miss180 got=%0h/%h exp=1/180", mem_req, mem_addr); end
    serve_fill(mk_line(32'h3000), 1);
    total++; if (instr !== 32'h3000)    begin bad++; $display("FAIL rr_fill180 got=%h exp=3000", instr); end
    pc = 32'h100; tick();
    total++; if (mem_req !== 1'b1)      begin bad++; $display("FAIL rr_evict100 got=%0h exp=1", mem_req); end
    serve_fill(mk_line(32'h4000), 1);
    total++; if (instr !== 32'h4000)    begin bad++; $display("FAIL rr_refill100 got=%h exp=4000", instr); end
    pc = 32'h184; tick();
    total++; if (instr !== 32'h3001 || stall !== 1'b0) begin bad++; $display("FAIL rr_hit184 got=%h/%0h exp=3001/0", instr, stall); end
    pc = 32'h140; tick();
    total++; if (mem_req !== 1'b1)      begin bad++; $display("FAIL rr_evict140 got=%0h exp=1", mem_req); end
    serve_fill(mk_line(32'h5000), 0);
    total++; if (miss_count !== 32'd5 || hit_count !== 32'd1) begin bad++; $display("FAIL rr_counts got=%0d/%0d exp=5/1", miss_count, hit_count); end
  endtask

  task automatic test_flush_lookup();
    do_reset();
    pc = 32'h100; tick(); serve_fill(mk_line(32'h1000), 0);
    pc = 32'h104; tick();
    total++; if (instr !== 32'h1001)    begin bad++; $display("FAIL fl_prehit got=%h exp=1001", instr); end
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (instr !== NOPV || stall !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fl_cycle got=%h/%0h/%0h exp=%h/0/0", instr, stall, mem_req, NOPV); end
    total++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin bad++; $display("FAIL fl_counts got=%0d/%0d exp=1/1", hit_count, miss_count); end
    pc = 32'h100; tick();
    total++; if (mem_req !== 1'b1 || miss_count !== 32'd2) begin bad++; $display("FAIL fl_remiss got=%0h/%0d exp=1/2", mem_req, miss_count); end
    serve_fill(mk_line(32'h1000), 0);
  endtask

  task automatic test_flush_wait();
    do_reset();
    pc = 32'h100; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    total++; if (mem_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL fw_hold got=%0h/%0h exp=1/1", mem_req, stall); end
    serve_fill(mk_line(32'h7000), 1);
    total++; if (instr !== 32'h7000 || stall !== 1'b0) begin bad++; $display("FAIL fw_deliver got=%h/%0h exp=7000/0", instr, stall); end
    tick();
    total++; if (mem_req !== 1'b1 || miss_count !== 32'd2) begin bad++; $display("FAIL fw_remiss got=%0h/%0d exp=1/2", mem_req, miss_count); end
    serve_fill(mk_line(32'h7000), 0);
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    pc = 32'h100; tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rmf_ctrl got=%0h/%0h exp=0/0", mem_req, stall); end
    total++; if (instr !== NOPV)        begin bad++; $display("FAIL rmf_instr got=%h exp=%h", instr, NOPV); end
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL rmf_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    // flush keeps LOOKUP from issuing its own miss while the stray pulse arrives
    flush = 1'b1; mem_line = mk_line(32'h9000); mem_ready = 1'b1; tick();
    mem_ready = 1'b0; tick(); flush = 1'b0;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0 || instr !== NOPV) begin bad++; $display("FAIL rmf_stray got=%0h/%0h/%h exp=0/0/%h", mem_req, stall, instr, NOPV); end
    tick();
    total++; if (mem_req !== 1'b1 || miss_count !== 32'd1) begin bad++; $display("FAIL rmf_nofill got=%0h/%0d exp=1/1", mem_req, miss_count); end
    serve_fill(mk_line(32'h6000), 0);
    total++; if (instr !== 32'h6000)    begin bad++; $display("FAIL rmf_newfill got=%h exp=6000", instr); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line_hits();
    test_assoc();
    test_round_robin();
    test_flush_lookup();
    test_flush_wait();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
